data_bus_adapter: RTL and testbench
===================================

Name: data_bus_adapter

Overview:
- Sits between the core's execute/writeback data port and the shared system bus.
- Converts a single load/store request into one bus transaction with a valid/ack handshake:
  - address, width, write-enable, zero-extend in;
  - byte-lane select, write-data replication and load extension out.
- Signals busy so the pipeline can stall.
- Detects misaligned accesses without touching the bus.

Parameters:
- ADDR_WIDTH, 32, width of request and bus address.
- TIMEOUT_CYCLES, 255, bus-wait limit before abort (used only with the optional feature; 8-bit counter, values 1..255).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_req_valid  input  1  request present this cycle.
- o_req_ready  output  1  adapter can accept a request (state IDLE).
- i_req_addr  input  ADDR_WIDTH  byte address.
- i_req_wdata  input  32  store data, right-aligned.
- i_req_width  input  2  1=byte, 2=half, 3=word, 0=illegal.
- i_req_we  input  1  1=store, 0=load.
- i_req_zext  input  1  load zero-extend (1) or sign-extend (0).
- o_resp_valid  output  1  one-cycle completion pulse.
- o_resp_rdata  output  32  extended load data; 0 for stores/errors.
- o_resp_err  output  1  misaligned, illegal width, bus error or timeout.
- o_busy  output  1  state != IDLE.
- o_bus_cyc  output  1  bus cycle active.
- o_bus_stb  output  1  bus strobe.
- o_bus_we  output  1  bus write.
- o_bus_adr  output  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2],2'b00}.
- o_bus_sel  output  4  byte-lane enables.
- o_bus_wdat  output  32  lane-replicated write data.
- i_bus_rdat  input  32  read data, valid with ack.
- i_bus_ack  input  1  transfer complete.
- i_bus_err  input  1  transfer failed.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - state=IDLE;
  - o_resp_valid, o_resp_err, o_bus_cyc, o_bus_stb, o_bus_we, o_bus_sel = 0;
  - o_resp_rdata, o_bus_adr, o_bus_wdat = 0.
  - Mid-transaction reset abandons the transfer. cyc/stb are low the next cycle. No response is issued.
- States: IDLE, BUS, RESP, ERR. o_req_ready=1 only in IDLE.
- IDLE, i_req_valid=1: latch addr/wdata/width/we/zext, then check alignment.
  - Misaligned or illegal width goes to ERR. This covers width 0, half with addr[0]=1, and word with addr[1:0]!=0.
  - Otherwise go to BUS.
- BUS:
  - cyc=stb=1; we, adr, sel, wdat are driven from latched values and held stable until the transfer ends.
  - sel: byte → 1<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
  - wdat: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
  - On i_bus_ack or i_bus_err: go to RESP and deassert cyc/stb on the next cycle.
  - Load data is captured on ack:
    - byte = i_bus_rdat[8*addr[1:0] +: 8];
    - half = i_bus_rdat[8*addr[1:0] +: 16];
    - each extended per zext; word is unchanged.
  - err and ack together: err wins, rdata=0.
- RESP: o_resp_valid=1 for exactly one cycle, o_resp_err from the captured err; next state IDLE.
- ERR: o_resp_valid=1, o_resp_err=1, rdata=0 for one cycle; no bus activity; next state IDLE.
- Latency:
  - request accepted cycle 0;
  - stb high from cycle 1;
  - ack at cycle k (k≥1) gives resp_valid at k+1;
  - misaligned gives resp_valid at cycle 1.
- The response has no backpressure; the consumer must take it in the pulse cycle.
- Requests are not accepted in RESP/ERR. A new request can be accepted in the cycle after resp_valid.
- i_bus_ack/i_bus_err outside BUS are ignored.
- Store completion: o_resp_rdata=0.

Optional Feature:
- Macro: DATA_BUS_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entry to BUS and increments each BUS cycle without ack/err.
  - When the count reaches TIMEOUT_CYCLES, cyc/stb drop on the next cycle and RESP issues with err=1, rdata=0.
  - An ack in the same cycle as the limit is honoured normally.
- Undefined: no counter; BUS waits indefinitely for ack/err.

Test Plan:
- Load word addr 0x40000008, i_bus_rdat=0xDEADBEEF with ack 2 cycles after stb → adr 0x40000008, sel 4'b1111, resp_valid one cycle later with rdata 0xDEADBEEF, err=0.
- Load byte addr 0x40000003, zext=0, rdat=0x80FFFFFF → sel 4'b1000, rdata 0xFFFFFF80; repeat with zext=1 → 0x00000080.
- Store half addr 0x40000002, wdata 0x1234ABCD → we=1, sel 4'b1100, wdat 0xABCDABCD; resp rdata 0, err 0.
- Word load addr 0x40000006 → no cyc/stb ever; resp_valid at cycle 1 with err=1; width 0 gives the same result.
- Ack and err asserted together on a word load → err=1, rdata=0. Reset pulled low while in BUS → cyc/stb 0 next cycle, no resp_valid, a late ack is ignored.
- With DATA_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → stb high 4 cycles then dropped, resp err=1.

Source files
------------

// File: rtl/data_bus_adapter_if.sv
// data_bus_adapter_if: request/response and system-bus signals of the data bus adapter.
interface data_bus_adapter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [31:0]           i_req_wdata;
  logic [1:0]            i_req_width;
  logic                  i_req_we;
  logic                  i_req_zext;
  logic                  o_resp_valid;
  logic [31:0]           o_resp_rdata;
  logic                  o_resp_err;
  logic                  o_busy;
  logic                  o_bus_cyc;
  logic                  o_bus_stb;
  logic                  o_bus_we;
  logic [ADDR_WIDTH-1:0] o_bus_adr;
  logic [3:0]            o_bus_sel;
  logic [31:0]           o_bus_wdat;
  logic [31:0]           i_bus_rdat;
  logic                  i_bus_ack;
  logic                  i_bus_err;
  modport slave (
    input  i_req_valid, i_req_addr, i_req_wdata, i_req_width, i_req_we, i_req_zext,
    input  i_bus_rdat, i_bus_ack, i_bus_err,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err, o_busy,
    output o_bus_cyc, o_bus_stb, o_bus_we, o_bus_adr, o_bus_sel, o_bus_wdat
  );
  modport master (
    output i_req_valid, i_req_addr, i_req_wdata, i_req_width, i_req_we, i_req_zext,
    output i_bus_rdat, i_bus_ack, i_bus_err,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err, o_busy,
    input  o_bus_cyc, o_bus_stb, o_bus_we, o_bus_adr, o_bus_sel, o_bus_wdat
  );
endinterface

// File: rtl/data_bus_adapter.sv
// data_bus_adapter: turns one core load/store into a single valid/ack bus transfer.
// Define DATA_BUS_TIMEOUT_EN to abort a bus wait after TIMEOUT_CYCLES cycles.
module data_bus_adapter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               i_clk,
  input logic               i_rst_n,
  data_bus_adapter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata, r_rdata, w_sh, w_load;
  logic [1:0]            r_width;
  logic                  r_we, r_zext, r_err, w_misalign, w_done, w_timeout;

  assign w_misalign = bus.i_req_width == 2'd0 ||
                      (bus.i_req_width == 2'd2 && bus.i_req_addr[0]) ||
                      (bus.i_req_width == 2'd3 && bus.i_req_addr[1:0] != 2'd0);
  assign w_done = bus.i_bus_ack || bus.i_bus_err || w_timeout;

`ifdef DATA_BUS_TIMEOUT_EN
  logic [7:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || r_state != BUS) r_cnt <= 8'd0;
    else r_cnt <= r_cnt + 8'd1;
  end
  assign w_timeout = r_state == BUS && r_cnt == 8'(TIMEOUT_CYCLES - 1);
`else
  // Limit is always 1..255 here, so this never fires: the bus waits indefinitely.
  assign w_timeout = TIMEOUT_CYCLES == 0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && bus.i_req_valid) w_next = w_misalign ? ERR : BUS;
    else if (r_state == BUS && w_done) w_next = RESP;
    else if (r_state == RESP || r_state == ERR) w_next = IDLE;
  end

  assign w_sh   = bus.i_bus_rdat >> {r_addr[1:0], 3'b000};
  assign w_load = r_width == 2'd1 ? {{24{~r_zext & w_sh[7]}}, w_sh[7:0]} :
                  r_width == 2'd2 ? {{16{~r_zext & w_sh[15]}}, w_sh[15:0]} : bus.i_bus_rdat;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_width <= 2'd0;
      r_we    <= 1'b0;
      r_zext  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else if (r_state == IDLE && bus.i_req_valid) begin
      r_addr  <= bus.i_req_addr;
      r_wdata <= bus.i_req_wdata;
      r_width <= bus.i_req_width;
      r_we    <= bus.i_req_we;
      r_zext  <= bus.i_req_zext;
    end else if (r_state == BUS && w_done) begin
      // Neither ack nor err means the wait timed out; err beats a simultaneous ack.
      r_err   <= bus.i_bus_err || !bus.i_bus_ack;
      r_rdata <= bus.i_bus_ack && !bus.i_bus_err && !r_we ? w_load : 32'd0;
    end
  end

  assign bus.o_req_ready  = r_state == IDLE;
  assign bus.o_busy       = r_state != IDLE;
  assign bus.o_bus_cyc    = r_state == BUS;
  assign bus.o_bus_stb    = r_state == BUS;
  assign bus.o_bus_we     = r_state == BUS && r_we;
  assign bus.o_bus_adr    = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus.o_bus_sel    = r_state != BUS ? 4'b0000 :
                            r_width == 2'd1 ? 4'b0001 << r_addr[1:0] :
                            r_width == 2'd2 ? 4'b0011 << r_addr[1:0] : 4'b1111;
  assign bus.o_bus_wdat   = r_width == 2'd1 ? {4{r_wdata[7:0]}} :
                            r_width == 2'd2 ? {2{r_wdata[15:0]}} : r_wdata;
  assign bus.o_resp_valid = r_state == RESP || r_state == ERR;
  assign bus.o_resp_err   = r_state == ERR || (r_state == RESP && r_err);
  assign bus.o_resp_rdata = r_state == RESP ? r_rdata : 32'd0;
endmodule

// File: tb/tb_data_bus_adapter.sv
// tb_data_bus_adapter: directed vectors, corner sequences and random transactions vs a reference model.
module tb_data_bus_adapter;
  logic clk, rst_n;
  int   checks = 0;
  int   failures = 0;

  data_bus_adapter_if #(.ADDR_WIDTH(32)) bif ();
  data_bus_adapter #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        we;
    logic        zext;
    logic [31:0] rdat;
    logic [7:0]  k;
    logic        ack;
    logic        err;
    logic        mis;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdata;
    logic        rerr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] w,
                                 input logic we, input logic zx, input logic [31:0] rd,
                                 input logic [7:0] k, input logic ack, input logic err);
    vec_t r;
    int off, nb;
    logic [31:0] v;
    off = int'(a % 4);
    nb = (w == 2'd3) ? 4 : int'(w);
    r.addr = a; r.wdata = wd; r.width = w; r.we = we; r.zext = zx; r.rdat = rd;
    r.k = k; r.ack = ack; r.err = err;
    r.mis = nb == 0 || (nb == 2 && off % 2 == 1) || (nb == 4 && off != 0);
    r.sel = 4'(((1 << nb) - 1) << off);
    r.wdat = nb == 1 ? (wd % 256) * 32'h01010101 : nb == 2 ? (wd % 65536) * 32'h00010001 : wd;
    r.rerr = r.mis || err || !ack;
    v = rd >> (8 * off);
    if (nb == 1) begin
      v = v % 256;
      if (!zx && v >= 128) v = v + 32'hFFFFFF00;
    end else if (nb == 2) begin
      v = v % 65536;
      if (!zx && v >= 32768) v = v + 32'hFFFF0000;
    end
    r.rdata = (r.rerr || we) ? 32'd0 : v;
    return r;
  endfunction

  task automatic garbage_req();
    bif.i_req_valid = 1'b1;
    bif.i_req_addr  = $urandom;
    bif.i_req_wdata = $urandom;
    bif.i_req_width = 2'($urandom_range(0, 3));
    bif.i_req_we    = 1'($urandom_range(0, 1));
    bif.i_req_zext  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_txn(input string name, input vec_t v);
    bif.i_req_valid = 1'b1;
    bif.i_req_addr  = v.addr;
    bif.i_req_wdata = v.wdata;
    bif.i_req_width = v.width;
    bif.i_req_we    = v.we;
    bif.i_req_zext  = v.zext;
    #1;
    chk({name, ":ready"}, 32'(bif.o_req_ready), 32'd1);
    @(posedge clk); #1;
    garbage_req();
    if (v.mis) begin
      bif.i_bus_ack = 1'($urandom_range(0, 1));
      #1;
      chk({name, ":stb"}, 32'(bif.o_bus_stb), 32'd0);
      chk({name, ":cyc"}, 32'(bif.o_bus_cyc), 32'd0);
    end else begin
      for (int c = 1; c <= int'(v.k); c++) begin
        if (c > 1) begin @(posedge clk); #1; end
        bif.i_bus_ack  = c == int'(v.k) && v.ack;
        bif.i_bus_err  = c == int'(v.k) && v.err;
        bif.i_bus_rdat = c == int'(v.k) ? v.rdat : $urandom;
        #1;
        chk({name, ":stb"}, 32'(bif.o_bus_stb), 32'd1);
        chk({name, ":cyc"}, 32'(bif.o_bus_cyc), 32'd1);
        chk({name, ":we"}, 32'(bif.o_bus_we), 32'(v.we));
        chk({name, ":adr"}, bif.o_bus_adr, v.addr - v.addr % 4);
        chk({name, ":sel"}, 32'(bif.o_bus_sel), 32'(v.sel));
        chk({name, ":wdat"}, bif.o_bus_wdat, v.wdat);
        chk({name, ":early_resp"}, 32'(bif.o_resp_valid), 32'd0);
        chk({name, ":busy_ready"}, {30'd0, bif.o_busy, bif.o_req_ready}, 32'd2);
      end
      @(posedge clk); #1;
      bif.i_bus_ack = 1'($urandom_range(0, 1));
      bif.i_bus_err = 1'($urandom_range(0, 1));
      #1;
      chk({name, ":stb_drop"}, 32'(bif.o_bus_stb), 32'd0);
      chk({name, ":cyc_drop"}, 32'(bif.o_bus_cyc), 32'd0);
    end
    chk({name, ":resp_valid"}, 32'(bif.o_resp_valid), 32'd1);
    chk({name, ":resp_err"}, 32'(bif.o_resp_err), 32'(v.rerr));
    chk({name, ":resp_rdata"}, bif.o_resp_rdata, v.rdata);
    chk({name, ":resp_ready"}, 32'(bif.o_req_ready), 32'd0);
    @(posedge clk); #1;
    bif.i_req_valid = 1'b0;
    bif.i_bus_ack   = 1'b0;
    bif.i_bus_err   = 1'b0;
    #1;
    chk({name, ":pulse_end"}, 32'(bif.o_resp_valid), 32'd0);
    chk({name, ":idle"}, {30'd0, bif.o_busy, bif.o_req_ready}, 32'd1);
  endtask

  vec_t tbl[12];

  initial begin
    vec_t r;
    tbl[0]  = '{32'h40000008, 32'h0, 2'd3, 1'b0, 1'b0, 32'hDEADBEEF, 8'd3, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{32'h40000003, 32'h0, 2'd1, 1'b0, 1'b0, 32'h80FFFFFF, 8'd1, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0};
    tbl[2]  = '{32'h40000003, 32'h0, 2'd1, 1'b0, 1'b1, 32'h80FFFFFF, 8'd1, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0, 32'h00000080, 1'b0};
    tbl[3]  = '{32'h40000002, 32'h1234ABCD, 2'd2, 1'b1, 1'b0, 32'h55555555, 8'd2, 1'b1, 1'b0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0};
    tbl[4]  = '{32'h40000006, 32'h0, 2'd3, 1'b0, 1'b0, 32'h0, 8'd1, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[5]  = '{32'h40000000, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0, 8'd1, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[6]  = '{32'h40000000, 32'h0, 2'd3, 1'b0, 1'b0, 32'h00001234, 8'd2, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1};
    tbl[7]  = '{32'h40000001, 32'h000000A5, 2'd1, 1'b1, 1'b0, 32'h0, 8'd1, 1'b0, 1'b1, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b1};
    tbl[8]  = '{32'h40000000, 32'h0, 2'd2, 1'b0, 1'b0, 32'h00008001, 8'd1, 1'b1, 1'b0, 1'b0, 4'b0011, 32'h0, 32'hFFFF8001, 1'b0};
    tbl[9]  = '{32'h40000001, 32'h000000A5, 2'd1, 1'b1, 1'b0, 32'h0, 8'd2, 1'b1, 1'b0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0};
    tbl[10] = '{32'h40000001, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 8'd1, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[11] = '{32'h40000002, 32'h0, 2'd1, 1'b0, 1'b0, 32'h00FF0000, 8'd4, 1'b1, 1'b0, 1'b0, 4'b0100, 32'h0, 32'hFFFFFFFF, 1'b0};

    rst_n = 1'b0;
    bif.i_req_valid = 1'b0; bif.i_req_addr = 32'h0; bif.i_req_wdata = 32'h0;
    bif.i_req_width = 2'd0; bif.i_req_we = 1'b0; bif.i_req_zext = 1'b0;
    bif.i_bus_rdat = 32'h0; bif.i_bus_ack = 1'b0; bif.i_bus_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst:cyc_stb_we", {29'd0, bif.o_bus_cyc, bif.o_bus_stb, bif.o_bus_we}, 32'd0);
    chk("rst:sel", 32'(bif.o_bus_sel), 32'd0);
    chk("rst:adr", bif.o_bus_adr, 32'd0);
    chk("rst:wdat", bif.o_bus_wdat, 32'd0);
    chk("rst:resp", {30'd0, bif.o_resp_valid, bif.o_resp_err}, 32'd0);
    chk("rst:rdata", bif.o_resp_rdata, 32'd0);
    chk("rst:busy_ready", {30'd0, bif.o_busy, bif.o_req_ready}, 32'd1);

    for (int i = 0; i < 12; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Bus handshake seen while idle must not start anything.
    bif.i_bus_ack = 1'b1; bif.i_bus_err = 1'b1;
    @(posedge clk); #1;
    bif.i_bus_ack = 1'b0; bif.i_bus_err = 1'b0;
    #1;
    chk("idle_ack:busy", 32'(bif.o_busy), 32'd0);
    chk("idle_ack:resp", 32'(bif.o_resp_valid), 32'd0);

    // Reset while the bus is waiting abandons the transfer.
    bif.i_req_valid = 1'b1; bif.i_req_addr = 32'h40000020; bif.i_req_width = 2'd3;
    bif.i_req_we = 1'b1; bif.i_req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bif.i_req_valid = 1'b0;
    #1;
    chk("mid_rst:stb_before", 32'(bif.o_bus_stb), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bif.i_bus_ack = 1'b1; bif.i_bus_rdat = 32'h12345678;
    #1;
    chk("mid_rst:cyc_stb", {30'd0, bif.o_bus_cyc, bif.o_bus_stb}, 32'd0);
    chk("mid_rst:resp", 32'(bif.o_resp_valid), 32'd0);
    chk("mid_rst:busy", 32'(bif.o_busy), 32'd0);
    @(posedge clk); #1;
    bif.i_bus_ack = 1'b0;
    #1;
    chk("mid_rst:late_ack_resp", 32'(bif.o_resp_valid), 32'd0);
    chk("mid_rst:late_ack_busy", 32'(bif.o_busy), 32'd0);

`ifdef DATA_BUS_TIMEOUT_EN
    bif.i_req_valid = 1'b1; bif.i_req_addr = 32'h40000010; bif.i_req_width = 2'd3;
    bif.i_req_we = 1'b0;
    @(posedge clk); #1;
    bif.i_req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      #1;
      chk($sformatf("tmo:stb_c%0d", c), 32'(bif.o_bus_stb), 32'd1);
    end
    @(posedge clk); #2;
    chk("tmo:stb_drop", 32'(bif.o_bus_stb), 32'd0);
    chk("tmo:resp", {30'd0, bif.o_resp_valid, bif.o_resp_err}, 32'd3);
    chk("tmo:rdata", bif.o_resp_rdata, 32'd0);
    @(posedge clk); #2;
    chk("tmo:idle", {30'd0, bif.o_resp_valid, bif.o_req_ready}, 32'd1);
`else
    run_txn("long_wait", model(32'h4000000C, 32'h0, 2'd3, 1'b0, 1'b0, 32'h0BADF00D, 8'd20, 1'b1, 1'b0));
`endif

    for (int n = 0; n < 80; n++) begin
      logic a, e;
      e = $urandom_range(0, 7) == 0;
      a = !e || $urandom_range(0, 1) == 1;
      r = model(32'h40000000 | ($urandom & 32'h00000FFF), $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                8'($urandom_range(1, 4)), a, e);
      run_txn($sformatf("rnd%0d", n), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
